// File: rtl/regfile_bank_if.sv
// Operand/write bus between decode and the register bank.
// Handshake: no valid/ready pair; we3 alone qualifies a write and clr alone requests a sweep, and
// busy=1 means the bank ignores both and returns 0 on both read ports.
interface regfile_bank_if #(
    parameter int WIDTH = 8,
    parameter int ABITS = 4
);
    logic             we3;
    logic [ABITS-1:0] wa3;
    logic [WIDTH-1:0] wd3;
    logic [ABITS-1:0] ra1;
    logic [ABITS-1:0] ra2;
    logic             clr;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic             busy;

    modport master (
        output we3, wa3, wd3, ra1, ra2, clr,
        input  rd1, rd2, busy
    );

    modport slave (
        input  we3, wa3, wd3, ra1, ra2, clr,
        output rd1, rd2, busy
    );
endinterface

// File: rtl/regfile_bank.sv
// 2-read/1-write register bank with optional zero r0, optional write bypass,
// and a sweep sequencer that zeroes every entry after reset or on clr.
module regfile_bank #(
    parameter int WIDTH   = 8,
    parameter int ABITS   = 4,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic           clk,
    input  logic           reset,
    regfile_bank_if.slave  bus,
    output logic           state_dbg
);
    localparam int DEPTH = 2 ** ABITS;
    localparam logic [ABITS-1:0] LAST = ABITS'(DEPTH - 1);

    typedef enum logic {READY = 1'b0, SWEEP = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [ABITS-1:0] cnt, cnt_nxt;
    logic             user_wr;
    logic             wr_en;
    logic [ABITS-1:0] wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SWEEP;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            SWEEP: begin
                cnt_nxt = cnt + ABITS'(1);
                if (cnt == LAST) state_nxt = READY;
            end
            default: begin
                if (bus.clr) begin
                    state_nxt = SWEEP;
                    cnt_nxt   = '0;
                end
            end
        endcase
    end

    // A user write is accepted only in READY, loses to clr, and is dropped for a hardwired r0.
    always_comb begin
        user_wr = (state == READY) && bus.we3 && !bus.clr &&
                  !((ZERO_R0 != 0) && (bus.wa3 == '0));
        wr_en   = 1'b0;
        wr_addr = bus.wa3;
        wr_data = bus.wd3;
        bus.busy = 1'b0;
        if (state == SWEEP) begin
            wr_en    = 1'b1;
            wr_addr  = cnt;
            wr_data  = '0;
            bus.busy = 1'b1;
        end else if (user_wr) begin
            wr_en = 1'b1;
        end
    end

    assign state_dbg = (state == SWEEP);

    // Array has no reset; gating on reset keeps edges during reset from touching it.
    always_ff @(posedge clk) begin
        if (reset && wr_en) mem[wr_addr] <= wr_data;
    end

    always_comb begin
        bus.rd1 = mem[bus.ra1];
        if ((BYPASS != 0) && user_wr && (bus.wa3 == bus.ra1)) bus.rd1 = bus.wd3;
        if ((state == SWEEP) || ((ZERO_R0 != 0) && (bus.ra1 == '0))) bus.rd1 = '0;
    end

    always_comb begin
        bus.rd2 = mem[bus.ra2];
        if ((BYPASS != 0) && user_wr && (bus.wa3 == bus.ra2)) bus.rd2 = bus.wd3;
        if ((state == SWEEP) || ((ZERO_R0 != 0) && (bus.ra2 == '0))) bus.rd2 = '0;
    end
endmodule

// File: tb/tb_regfile_bank.sv
// Bench for regfile_bank: default 16x8 instance (zero r0, bypass) and a 32x16 instance
// (normal r0, no bypass) driven side by side and compared against a behavioural model.
module tb_regfile_bank;
    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [15:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic        clr;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [15:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic        clr;
        logic [15:0] e1;
        logic [15:0] e2;
    } row_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic sd_a, sd_b;
    int   checks = 0;
    int   errors = 0;

    vec_t        cur [2];
    logic [15:0] mem_m [2][32];
    int          left [2];
    int          depth [2];
    int          zero [2];
    int          byp [2];

    always #5 clk = ~clk;

    regfile_bank_if #(.WIDTH(8),  .ABITS(4)) bus_a ();
    regfile_bank_if #(.WIDTH(16), .ABITS(5)) bus_b ();

    regfile_bank #(.WIDTH(8), .ABITS(4), .ZERO_R0(1), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave), .state_dbg(sd_a)
    );
    regfile_bank #(.WIDTH(16), .ABITS(5), .ZERO_R0(0), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave), .state_dbg(sd_b)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_rd(input int c, input logic [4:0] ra);
        if (left[c] > 0) return 16'h0;
        if (zero[c] != 0 && ra == 5'd0) return 16'h0;
        if (byp[c] != 0 && cur[c].we && !cur[c].clr && cur[c].wa == ra &&
            !(zero[c] != 0 && cur[c].wa == 5'd0)) return cur[c].wd;
        return mem_m[c][ra];
    endfunction

    task automatic model_edge(input int c);
        if (!reset) begin
            left[c] = depth[c];
        end else if (left[c] > 0) begin
            mem_m[c][depth[c] - left[c]] = 16'h0;
            left[c]--;
        end else if (cur[c].clr) begin
            left[c] = depth[c];
        end else if (cur[c].we && !(zero[c] != 0 && cur[c].wa == 5'd0)) begin
            mem_m[c][cur[c].wa] = cur[c].wd;
        end
    endtask

    task automatic idle();
        for (int c = 0; c < 2; c++) cur[c] = '{1'b0, 5'd0, 16'h0, 5'd0, 5'd0, 1'b0};
    endtask

    // Drive both buses from cur, let reads settle, compare against the model.
    task automatic apply();
        bus_a.we3 = cur[0].we;  bus_a.wa3 = cur[0].wa[3:0]; bus_a.wd3 = cur[0].wd[7:0];
        bus_a.ra1 = cur[0].ra1[3:0]; bus_a.ra2 = cur[0].ra2[3:0]; bus_a.clr = cur[0].clr;
        bus_b.we3 = cur[1].we;  bus_b.wa3 = cur[1].wa; bus_b.wd3 = cur[1].wd;
        bus_b.ra1 = cur[1].ra1; bus_b.ra2 = cur[1].ra2; bus_b.clr = cur[1].clr;
        #2;
        check("a_busy", {15'h0, bus_a.busy}, {15'h0, left[0] > 0});
        check("a_state", {15'h0, sd_a}, {15'h0, left[0] > 0});
        check("a_rd1", {8'h0, bus_a.rd1}, exp_rd(0, cur[0].ra1));
        check("a_rd2", {8'h0, bus_a.rd2}, exp_rd(0, cur[0].ra2));
        check("b_busy", {15'h0, bus_b.busy}, {15'h0, left[1] > 0});
        check("b_state", {15'h0, sd_b}, {15'h0, left[1] > 0});
        check("b_rd1", bus_b.rd1, exp_rd(1, cur[1].ra1));
        check("b_rd2", bus_b.rd2, exp_rd(1, cur[1].ra2));
    endtask

    task automatic edge_();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        left[0] = depth[0];
        left[1] = depth[1];
        idle();
        for (int i = 0; i < n; i++) begin
            apply();
            edge_();
        end
        reset = 1'b1;
    endtask

    task automatic count_busy(input int exp_a, input int exp_b);
        int na = 0;
        int nb = 0;
        idle();
        for (int i = 0; i < 100; i++) begin
            apply();
            if (bus_a.busy) na++;
            if (bus_b.busy) nb++;
            if (!bus_a.busy && !bus_b.busy) break;
            edge_();
        end
        check("a_sweep_len", 16'(na), 16'(exp_a));
        check("b_sweep_len", 16'(nb), 16'(exp_b));
    endtask

    task automatic check_all_zero();
        for (int i = 0; i < 32; i++) begin
            idle();
            cur[0].ra1 = 5'(i % 16); cur[0].ra2 = 5'(15 - (i % 16));
            cur[1].ra1 = 5'(i);      cur[1].ra2 = 5'(31 - i);
            apply();
            check("a_zero_rd1", {8'h0, bus_a.rd1}, 16'h0);
            check("b_zero_rd1", bus_b.rd1, 16'h0);
            check("b_zero_rd2", bus_b.rd2, 16'h0);
            edge_();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        row_t tbl [8];
        tbl[0] = '{1'b1, 5'd5,  16'h00A7, 5'd5,  5'd5,  1'b0, 16'h00A7, 16'h00A7};
        tbl[1] = '{1'b0, 5'd0,  16'h0000, 5'd5,  5'd0,  1'b0, 16'h00A7, 16'h0000};
        tbl[2] = '{1'b1, 5'd0,  16'h00FF, 5'd0,  5'd5,  1'b0, 16'h0000, 16'h00A7};
        tbl[3] = '{1'b0, 5'd0,  16'h0000, 5'd0,  5'd0,  1'b0, 16'h0000, 16'h0000};
        tbl[4] = '{1'b1, 5'd9,  16'h003C, 5'd9,  5'd8,  1'b0, 16'h003C, 16'h0000};
        tbl[5] = '{1'b0, 5'd0,  16'h0000, 5'd9,  5'd9,  1'b0, 16'h003C, 16'h003C};
        tbl[6] = '{1'b1, 5'd15, 16'h0081, 5'd14, 5'd15, 1'b0, 16'h0000, 16'h0081};
        tbl[7] = '{1'b0, 5'd0,  16'h0000, 5'd15, 5'd5,  1'b0, 16'h0081, 16'h00A7};

        depth[0] = 16; zero[0] = 1; byp[0] = 1;
        depth[1] = 32; zero[1] = 0; byp[1] = 0;
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 32; i++) mem_m[c][i] = 16'h0;
        idle();
        @(negedge clk);

        // Reset held 3 cycles, then the full sweep and an all-zero bank.
        do_reset(3);
        count_busy(16, 32);
        check_all_zero();

        // Directed table on the 16x8 instance: bypass, r0 write drop, read-back.
        for (int i = 0; i < 8; i++) begin
            idle();
            cur[0] = '{tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra1, tbl[i].ra2, tbl[i].clr};
            apply();
            check($sformatf("tbl%0d_rd1", i), {8'h0, bus_a.rd1}, tbl[i].e1);
            check($sformatf("tbl%0d_rd2", i), {8'h0, bus_a.rd2}, tbl[i].e2);
            edge_();
        end

        // r0 is an ordinary register on the 32x16 instance, and there is no bypass.
        idle();
        cur[1] = '{1'b1, 5'd0, 16'hBEEF, 5'd0, 5'd0, 1'b0};
        apply();
        check("b_r0_nobypass", bus_b.rd1, 16'h0000);
        edge_();
        idle();
        apply();
        check("b_r0_readback", bus_b.rd1, 16'hBEEF);
        edge_();

        // Fill, then clr together with a write: the write is lost and everything clears.
        for (int i = 1; i < 16; i++) begin
            idle();
            cur[0] = '{1'b1, 5'(i), 16'($urandom_range(1, 255)), 5'(i), 5'd3, 1'b0};
            cur[1] = '{1'b1, 5'(i), 16'($urandom_range(1, 65535)), 5'(i), 5'd3, 1'b0};
            apply();
            edge_();
        end
        idle();
        cur[0] = '{1'b1, 5'd3, 16'h0055, 5'd3, 5'd3, 1'b1};
        cur[1] = '{1'b1, 5'd3, 16'h0055, 5'd3, 5'd3, 1'b1};
        apply();
        check("a_clr_no_bypass", {8'h0, bus_a.rd1}, mem_m[0][3]);
        edge_();
        count_busy(16, 32);
        check_all_zero();

        // Reset in the middle of a sweep (cnt=7) restarts it from entry 0.
        do_reset(2);
        for (int i = 0; i < 7; i++) begin
            idle();
            cur[0].clr = 1'b1; cur[1].we = 1'b1; cur[1].wa = 5'd4; cur[1].wd = 16'h1234;
            apply();
            edge_();
        end
        do_reset(2);
        count_busy(16, 32);

        // Random traffic with occasional clr.
        for (int n = 0; n < 400; n++) begin
            cur[0] = '{1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)),
                       16'($urandom_range(0, 255)), 5'($urandom_range(0, 15)),
                       5'($urandom_range(0, 15)), ($urandom_range(0, 63) == 0)};
            cur[1] = '{1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                       16'($urandom_range(0, 65535)), 5'($urandom_range(0, 31)),
                       5'($urandom_range(0, 31)), ($urandom_range(0, 63) == 0)};
            if ($urandom_range(0, 3) == 0) cur[0].ra1 = cur[0].wa;
            if ($urandom_range(0, 3) == 0) cur[1].ra2 = cur[1].wa;
            apply();
            edge_();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
